// File: rtl/mul_sequencer.sv
// Multi-cycle RV32M multiply sequencer: radix-2 shift-add over magnitudes,
// sign fix-up at the end, selected product half returned with a done strobe.
module mul_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   // state | meaning
   // IDLE  | waiting for a multiply request
   // LOAD  | form operand magnitudes and negate flag, clear accumulator
   // RUN   | one shift-add step per cycle, XLEN cycles
   // FIX   | apply sign correction, select product half into result
   // DONE  | done strobe, result valid
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   localparam logic [1:0] F_MUL    = 2'b00;
   localparam logic [1:0] F_MULH   = 2'b01;
   localparam logic [1:0] F_MULHSU = 2'b10;

   state_t              state_q, state_d;
   logic [1:0]          f3_q, f3_d;
   logic [XLEN-1:0]     op1_q, op1_d;
   logic [XLEN-1:0]     op2_q, op2_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                sign1;
   logic                sign2;
   logic [XLEN-1:0]     mag1;
   logic [XLEN-1:0]     mag2;
   logic [2*XLEN-1:0]   product;

   assign sign1 = ((f3_q == F_MULH) || (f3_q == F_MULHSU)) && op1_q[XLEN-1];
   assign sign2 = (f3_q == F_MULH) && op2_q[XLEN-1];
   // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
   assign mag1  = sign1 ? (~op1_q + 1'b1) : op1_q;
   assign mag2  = sign2 ? (~op2_q + 1'b1) : op2_q;
   assign product = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         f3_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start && !funct3[2]) begin
               f3_d    = funct3[1:0];
               op1_d   = operand1;
               op2_d   = operand2;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            mcand_d  = {{XLEN{1'b0}}, mag1};
            mplier_d = mag2;
            neg_d    = sign1 ^ sign2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_RUN;
         end
         S_RUN: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = (f3_q == F_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign stall  = busy | (start & ~funct3[2] & (state_q == S_IDLE));
   assign result = result_q;

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle RV32M multiply sequencer between the instruction decoder and register-file writeback. It accepts a MUL/MULH/MULHSU/MULHU request with both operands and stalls the processor while a radix-2 shift-add loop runs. It then applies the sign correction and returns the selected 32-bit half of the 64-bit product with a one-cycle `done` strobe.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`, input, 1: clock; all state updates on rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: request strobe from decode; sampled only in IDLE.
- `funct3`, input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is not a multiply.
- `operand1`, input, 32: rs1 value (multiplicand); sampled with `start`.
- `operand2`, input, 32: rs2 value (multiplier); sampled with `start`.
- `busy`, output, 1: operation in progress (LOAD through DONE).
- `stall`, output, 1: freeze PC/pipeline; combinational = `busy` | (`start` & ~`funct3[2]` & state==IDLE).
- `done`, output, 1: one-cycle strobe; `result` is valid in this cycle and holds afterwards.
- `result`, output, 32: selected product half; holds its value until the next `done`.

## Operation
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE: on `start`=1 with `funct3[2]`=0:
  - latch funct3 and operands, go to LOAD.
  - `start` with `funct3[2]`=1: ignored; no state change, no stall.
- LOAD (1 cycle): form magnitudes and the negate flag.
  - op1 is treated as signed for MULH and MULHSU.
  - op2 is treated as signed for MULH only.
  - Signed operand with bit31=1 is replaced by its two's-complement negation. 0x80000000 maps to unsigned 0x80000000; no overflow.
  - neg = sign1 ^ sign2, using signed-treated operands only.
  - Clear the 64-bit accumulator and the 5-bit counter; go to RUN.
- RUN (exactly 32 cycles, counter 0..31):
  - If the multiplier-magnitude LSB is 1, accumulator += multiplicand magnitude (64-bit, zero-extended).
  - Multiplicand shifts left 1 (64-bit), multiplier shifts right 1.
  - Counter wraps 31→0 on exit; go to FIX.
- No early termination: latency is fixed regardless of operand values.
- FIX (1 cycle):
  - If neg, product = ~acc + 1 (64-bit); a zero product stays zero.
  - `result` <= product[31:0] for MUL, product[63:32] otherwise. Go to DONE.
- DONE (1 cycle): `done`=1, `busy`=1; go to IDLE.
- `start` in any state other than IDLE is ignored; requests are never queued.
- MUL low half is identical for all sign interpretations; the sequencer still runs with funct3=000 as unsigned×unsigned.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE, `busy`=0, `done`=0, `result`=0.
  - counter and accumulator cleared.
- Reset dominates every state, including mid-RUN; the aborted operation produces no `done`.
- Let edge E0 be the edge that samples `start` in IDLE:
  - LOAD follows E0.
  - RUN spans edges E1..E32.
  - FIX at E33.
  - `done`=1 in the cycle after E34, i.e. 35 cycles after `start` is sampled.
  - Back in IDLE after E35.
- `busy` is high from E0+ through the DONE cycle (35 cycles).
- `stall` is high in the request cycle itself (combinational) and all 35 busy cycles.
- Processor contract:
  - Decode keeps `start`, `funct3` and operands stable while `stall`=1.
  - Writeback takes `result` on `done`.
  - `start` seen in the DONE cycle is ignored. The held instruction re-asserts it after `stall` drops, so it is re-accepted in the next IDLE cycle.
- Back-to-back operations: minimum spacing is 36 cycles start-to-start.

## Test plan
- Reset then MUL (000), op1=7, op2=6:
  - `stall` high in the request cycle.
  - `done` exactly 35 cycles later, `result`=0x0000002A.
  - `busy` low one cycle after `done`.
- Sign handling with op1=op2=0xFFFFFFFF:
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MUL → 0x00000001.
- MULHSU with op1=0xFFFFFFFF, op2=2 → 0xFFFFFFFF.
- MULH with op1=op2=0x80000000 → 0x40000000.
- Zero and negative cases:
  - MULH with op1=0, op2=0x80000000 → 0x00000000 (zero with neg flag).
  - MUL with op1=0xFFFFFFFD (-3), op2=5 → 0xFFFFFFF1.
- Ignored and aborted requests:
  - Assert `rst_n`=0 at RUN cycle 10 → next cycle `busy`=0, `done`=0, `result`=0, and no `done` afterwards.
  - `start` pulsed mid-RUN with different operands → ignored; first result is unchanged.
  - `start` with funct3=100 in IDLE → no `busy`, no `stall`.
